avalon_mm_cut_bridge: RTL

// - Registered Avalon-MM bridge inserted between one bus master and one master port of AvalonBusMatrix.
// - Breaks the long combinational paths (addr/wrdata in, 512-bit rddata/waitreq out) through the matrix.
// - Handles one outstanding transfer at a time; no readdatavalid, waitrequest-terminated transfers only.

---
 rtl/avalon_bridge_pkg.sv | 13 +
 rtl/avalon_bridge_timeout_cnt.sv | 49 ++++
 rtl/avalon_mm_cut_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/avalon_bridge_pkg.sv
// Shared definitions for the registered Avalon-MM cut bridge.
// Holds the bridge FSM encoding and the downstream abort fill pattern.
package avalon_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_bridge_timeout_cnt.sv
// Downstream stall counter with sticky timeout flag.
// Only instantiated when AVB_BRIDGE_TIMEOUT_EN is defined.
module avalon_bridge_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_start,
  input  logic i_issue,
  input  logic i_wait,
  input  logic i_clr,
  output logic o_expire,
  output logic o_err
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign o_expire = i_issue & i_wait & (r_cnt == LIMIT);
  assign o_err    = r_err;

  // Count stalled ISSUE cycles; restart on every new transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_issue & i_wait & ~o_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky error: a new abort wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (o_expire) begin
      r_err <= 1'b1;
    end else if (i_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_mm_cut_bridge.sv
// Registered Avalon-MM bridge: one outstanding transfer, all outputs flopped.
// Optional downstream stall timeout enabled by AVB_BRIDGE_TIMEOUT_EN.
module avalon_mm_cut_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 512,
  parameter int BE_W           = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] SlvAddr_i,
  input  logic [BE_W-1:0]   SlvByteEn_i,
  input  logic              SlvRdEn_i,
  input  logic              SlvWrEn_i,
  input  logic [DATA_W-1:0] SlvWrData_i,
  output logic [DATA_W-1:0] SlvRdData_o,
  output logic              SlvWaitReq_o,
  output logic [ADDR_W-1:0] MstAddr_o,
  output logic [BE_W-1:0]   MstByteEn_o,
  output logic              MstRdEn_o,
  output logic              MstWrEn_o,
  output logic [DATA_W-1:0] MstWrData_o,
  input  logic [DATA_W-1:0] MstRdData_i,
  input  logic              MstWaitReq_i,
  input  logic              ErrClr_i,
  output logic              TimeoutErr_o
);

  localparam logic [DATA_W-1:0] ABORT_DATA =
    {(DATA_W/32){ABORT_PATTERN}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_waitreq;
  logic              w_start;
  logic              w_abort;

  assign w_start = (r_state == ST_IDLE) & (SlvRdEn_i | SlvWrEn_i);

  assign MstAddr_o    = r_addr;
  assign MstByteEn_o  = r_be;
  assign MstRdEn_o    = r_rd;
  assign MstWrEn_o    = r_wr;
  assign MstWrData_o  = r_wdata;
  assign SlvRdData_o  = r_rdata;
  assign SlvWaitReq_o = r_waitreq;

`ifdef AVB_BRIDGE_TIMEOUT_EN
  logic w_issue;

  assign w_issue = (r_state == ST_ISSUE);

  avalon_bridge_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (w_start),
    .i_issue  (w_issue),
    .i_wait   (MstWaitReq_i),
    .i_clr    (ErrClr_i),
    .o_expire (w_abort),
    .o_err    (TimeoutErr_o)
  );
`else
  logic w_unused;

  assign w_abort      = 1'b0;
  assign TimeoutErr_o = 1'b0;
  assign w_unused     = ErrClr_i | (TIMEOUT_CYCLES == 0);
`endif

  // Bridge FSM; capture regs double as the downstream
  // outputs and are zeroed whenever ISSUE is left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_rdata   <= '0;
      r_waitreq <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_waitreq <= 1'b1;
          if (w_start) begin
            r_addr  <= SlvAddr_i;
            r_be    <= SlvByteEn_i;
            r_wdata <= SlvWrData_i;
            r_rd    <= SlvRdEn_i;
            r_wr    <= SlvWrEn_i & ~SlvRdEn_i;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!MstWaitReq_i || w_abort) begin
            if (w_abort) begin
              r_rdata <= ABORT_DATA;
            end else if (r_rd) begin
              r_rdata <= MstRdData_i;
            end
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_waitreq <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_waitreq <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_addr    <= '0;
          r_be      <= '0;
          r_wdata   <= '0;
          r_rd      <= 1'b0;
          r_wr      <= 1'b0;
          r_waitreq <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
